pp_combine_78: RTL
==================

# pp_combine_78

Recombines the 15 partial products of the 78-bit radix multiplier into the full 156-bit product. It sits directly downstream of the 3×5 DSP partial-product array (26-bit A limbs, 17-bit B limbs). It aligns a valid strobe with the DSP pipeline, then sums the shifted partial products in a two-stage registered adder tree. It is fixed-latency streaming with no back-pressure, because the upstream array has no stall input.

## Interface
- DSP_LAT, 3: cycles from presenting a/b to the multiplier until pp_0..pp_14 are valid.
- RADIX, 78: operand width. Only 78 is supported; the limb split is fixed.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  high in the same cycle that a/b are driven into the multiplier.
- pp_0..pp_14  in  43 each  partial products.
  - pp_{5k+j} = a_limb[k] * b_limb[j], for k in 0..2 and j in 0..4.
- prod  out  156  registered full product a*b.
- out_valid  out  1  registered; high for one cycle per accepted in_valid.

## Operation
- Limb weights:
  - a_limb[k] has weight 2^(26k).
  - b_limb[j] has weight 2^(17j).
  - pp_{5k+j} is therefore weighted by 2^(26k+17j).
- Upper bits of pp_4, pp_9 and pp_14 (b limb 4 is 10 bits wide) are added as received; they are not masked.
- Valid alignment:
  - in_valid enters a DSP_LAT-deep shift register, reset to all zeros.
  - Its tail, v_pp, marks the cycle in which pp_* are valid.
  - pp_* are sampled only when v_pp = 1. When v_pp = 0, stage registers keep their previous value.
- Stage 1, on the edge where v_pp = 1:
  - row[k] = Σ_j pp_{5k+j} << 17j, for k = 0..2.
  - Each row is 104 bits and is registered.
  - v1 <= v_pp.
- Stage 2, on the edge where v1 = 1:
  - prod <= row[0] + (row[1] << 26) + (row[2] << 52), truncated to 156 bits. No overflow is possible because a, b < 2^78.
  - out_valid <= v1.
- All sums are unsigned. Intermediate widths must hold the full sum; no bits are dropped before the 156-bit result.
- prod holds its last value while out_valid = 0.

## Timing
- Reset: when rst_n = 0 at a rising edge, the following are all cleared to 0 on that edge:
  - the valid shift register
  - v1
  - out_valid
  - prod
  - row registers
- Latency: in_valid sampled at edge E0 gives prod/out_valid updated at edge E(DSP_LAT+2). That is 5 cycles at the default.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid in the same order, with the same gaps.
- Bubbles: a gap in in_valid reproduces as an identical gap in out_valid. prod is not updated during the gap.
- Reset mid-operation: every in-flight valid is discarded.
  - No out_valid is produced for any transaction accepted before the reset edge, even if its pp_* arrive after rst_n returns high.
  - The first transaction after release is in_valid sampled with rst_n = 1. It completes with normal latency.
- in_valid sampled while rst_n = 0 is ignored.
- No combinational path from any input to any output.

## Test plan
- Reset values:
  - Stimulus: hold rst_n = 0 for 4 cycles.
  - Required: prod = 0 and out_valid = 0 throughout, and for DSP_LAT+2 cycles after release while in_valid = 0.
- Unit product:
  - Stimulus: a = 1, b = 1, single in_valid pulse, bench models pp_* with DSP_LAT delay.
  - Required: out_valid is high exactly at E5, with prod = 1.
- Top limbs:
  - Stimulus: a = 2^52, b = 2^68 (only pp_14 nonzero, = 1).
  - Required: prod = 2^120.
  - Stimulus: a = b = 2^78−1.
  - Required: prod = 2^156 − 2^79 + 1.
- Streaming:
  - Stimulus: 20 random (a, b) pairs on consecutive cycles, then 3 idle cycles, then 5 more.
  - Required: 20 consecutive out_valid pulses, then a 3-cycle gap, then 5 more, with each prod equal to a*b in order.
- Reset mid-flight:
  - Stimulus: issue 3 transactions, pulse rst_n low for 1 cycle at E2, then issue 1 new transaction.
  - Required: none of the first 3 produce out_valid; the new one appears with 5-cycle latency and correct prod.

Source files
------------

// File: rtl/pp_combine_78.sv
// pp_combine_78: recombines the 15 partial products of the 78x78 radix
// multiplier (3 A limbs of 26 bits x 5 B limbs of 17 bits) into the full
// 156-bit product, using a valid delay line matched to the DSP pipeline and
// a two-stage registered adder tree.
module pp_combine_78 #(
    parameter int DSP_LAT = 3,
    parameter int RADIX   = 78
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [42:0]          pp_0,
    input  logic [42:0]          pp_1,
    input  logic [42:0]          pp_2,
    input  logic [42:0]          pp_3,
    input  logic [42:0]          pp_4,
    input  logic [42:0]          pp_5,
    input  logic [42:0]          pp_6,
    input  logic [42:0]          pp_7,
    input  logic [42:0]          pp_8,
    input  logic [42:0]          pp_9,
    input  logic [42:0]          pp_10,
    input  logic [42:0]          pp_11,
    input  logic [42:0]          pp_12,
    input  logic [42:0]          pp_13,
    input  logic [42:0]          pp_14,
    output logic [2*RADIX-1:0]   prod,
    output logic                 out_valid
);

    localparam int PP_W   = 43;
    localparam int PROD_W = 2 * RADIX;
    // Wide enough for five partial products shifted by up to 68 bits, so the
    // unmasked upper bits of the top B-limb products are never dropped.
    localparam int ROW_W  = PP_W + 4 * 17 + 1;

    logic [PP_W-1:0]   pp [15];
    logic [DSP_LAT:0]  valid_sr;
    logic              v_pp;
    logic              v1;
    logic [ROW_W-1:0]  row_sum [3];
    logic [ROW_W-1:0]  row_q   [3];
    logic [PROD_W-1:0] prod_sum;

    assign pp[0]  = pp_0;
    assign pp[1]  = pp_1;
    assign pp[2]  = pp_2;
    assign pp[3]  = pp_3;
    assign pp[4]  = pp_4;
    assign pp[5]  = pp_5;
    assign pp[6]  = pp_6;
    assign pp[7]  = pp_7;
    assign pp[8]  = pp_8;
    assign pp[9]  = pp_9;
    assign pp[10] = pp_10;
    assign pp[11] = pp_11;
    assign pp[12] = pp_12;
    assign pp[13] = pp_13;
    assign pp[14] = pp_14;

    // The tail of the delay line is high in the cycle the DSP array presents
    // the partial products belonging to an accepted in_valid.
    assign v_pp = valid_sr[DSP_LAT];

    // Valid delay line: in_valid captured at E0 reaches v_pp after E(DSP_LAT).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[DSP_LAT-1:0], in_valid};
        end
    end

    // Row sums: each A limb's five products aligned on 17-bit B-limb weights.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            row_sum[k] = '0;
            for (int j = 0; j < 5; j++) begin
                row_sum[k] = row_sum[k] + (ROW_W'(pp[5*k+j]) << (17 * j));
            end
        end
    end

    // Stage 1: capture the three rows only when the partial products are valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                row_q[k] <= '0;
            end
        end else begin
            v1 <= v_pp;
            if (v_pp) begin
                for (int k = 0; k < 3; k++) begin
                    row_q[k] <= row_sum[k];
                end
            end
        end
    end

    // Final sum: rows weighted by the 26-bit A-limb spacing, full 156 bits.
    always_comb begin
        prod_sum = PROD_W'(row_q[0])
                 + (PROD_W'(row_q[1]) << 26)
                 + (PROD_W'(row_q[2]) << 52);
    end

    // Stage 2: register the product; it holds its value between results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                prod <= prod_sum;
            end
        end
    end

endmodule
